// File: rtl/dma_seq_pkg.sv
// Shared definitions for the descriptor-chained DMA sequencer:
// strobe positions, descriptor geometry, byte->strobe map and FSM encoding.
package dma_seq_pkg;

  localparam int DMA_PW     = 9;
  localparam int DESC_BYTES = 9;
  localparam int DESC_W     = DESC_BYTES * 8;

  localparam int DMA_SADDRL = 0;
  localparam int DMA_SADDRH = 1;
  localparam int DMA_SADDRX = 2;
  localparam int DMA_DADDRL = 3;
  localparam int DMA_DADDRH = 4;
  localparam int DMA_DADDRX = 5;
  localparam int DMA_LEN    = 6;
  localparam int DMA_CTRL   = 7;
  localparam int DMA_NUM    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_WSETTLE,
    ST_WAIT
  } seq_state_t;

  // Descriptor byte index to one-hot DMA register strobe; num and ctrl swap
  // places so that the launching ctrl write is always the last one issued.
  function automatic logic [DMA_PW-1:0] byte_strb(input logic [3:0] idx);
    logic [DMA_PW-1:0] s;
    s = '0;
    case (idx)
      4'd0:    s[DMA_SADDRL] = 1'b1;
      4'd1:    s[DMA_SADDRH] = 1'b1;
      4'd2:    s[DMA_SADDRX] = 1'b1;
      4'd3:    s[DMA_DADDRL] = 1'b1;
      4'd4:    s[DMA_DADDRH] = 1'b1;
      4'd5:    s[DMA_DADDRX] = 1'b1;
      4'd6:    s[DMA_LEN]    = 1'b1;
      4'd7:    s[DMA_NUM]    = 1'b1;
      4'd8:    s[DMA_CTRL]   = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dma_seq_fifo.sv
// Descriptor FIFO: DEPTH entries of W bits, flush has priority over push/pop.
module dma_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_ovf_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == CNT_MAX);
  assign o_empty   = (r_cnt == '0);
  assign o_level   = r_cnt;
  assign o_head    = r_mem[r_rptr];
  // A simultaneous pop frees the slot the push needs, so a full queue still accepts it.
  assign w_do_push = i_push && (!o_full || i_pop) && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_ovf_evt = i_push && o_full && !i_pop && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/dma_seq.sv
// Descriptor-chained sequencer: stages Z80 descriptors, replays them as DMA
// register writes and arbitrates the DMA register port with direct Z80 writes.
module dma_seq
  import dma_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = DMA_PW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             zdata,
  input  logic [PW-1:0]          zport_wr,
  input  logic                   stg_wr,
  input  logic [3:0]             stg_idx,
  input  logic                   q_push,
  input  logic                   q_flush,
  input  logic                   err_clr,
  input  logic                   dma_act,
  output logic [PW-1:0]          dmaport_wr,
  output logic [7:0]             dma_zdata,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   q_full,
  output logic                   busy,
  output logic                   chain_done,
  output logic                   z_conflict,
  output logic                   q_ovf
);

  logic [7:0]        r_stg [DESC_BYTES];
  logic [DESC_W-1:0] w_stg_img;
  logic [DESC_W-1:0] w_head;
  logic [DESC_W-1:0] r_desc;
  seq_state_t        r_state, w_nxt_state;
  logic [2:0]        r_cnt, w_nxt_cnt;
  logic [PW-1:0]     w_strb;
  logic [7:0]        w_data;
  logic              w_pop, w_done, w_empty, w_ovf_evt, w_conf_evt, w_have;
  logic [PW-1:0]     r_dmaport_wr;
  logic [7:0]        r_dma_zdata;
  logic              r_chain_done, r_z_conflict, r_q_ovf;

  always_comb begin
    w_stg_img = '0;
    for (int i = 0; i < DESC_BYTES; i++) w_stg_img[i*8 +: 8] = r_stg[i];
  end

  // Staging is written at the clock edge, so a same-cycle push sees the old image.
  always_ff @(posedge clk) begin
    if (stg_wr && (stg_idx < 4'(DESC_BYTES))) r_stg[stg_idx] <= zdata;
  end

  dma_seq_fifo #(.DEPTH(DEPTH), .W(DESC_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (q_push),
    .i_pop    (w_pop),
    .i_flush  (q_flush),
    .i_data   (w_stg_img),
    .o_head   (w_head),
    .o_level  (q_level),
    .o_full   (q_full),
    .o_empty  (w_empty),
    .o_ovf_evt(w_ovf_evt)
  );

  assign w_have     = !w_empty && !q_flush;
  assign w_conf_evt = (r_state != ST_IDLE) && (zport_wr != '0);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_strb      = '0;
    w_data      = r_dma_zdata;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_strb = zport_wr;
        w_data = zdata;
        if (w_have && !dma_act && (zport_wr == '0)) begin
          w_nxt_state = ST_LOAD;
          w_nxt_cnt   = '0;
          w_pop       = 1'b1;
        end
      end
      ST_LOAD: begin
        w_strb    = byte_strb({1'b0, r_cnt});
        w_data    = r_desc[{r_cnt, 3'b000} +: 8];
        w_nxt_cnt = r_cnt + 3'd1;
        if (r_cnt == 3'd7) w_nxt_state = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_strb      = byte_strb(4'd8);
        w_data      = r_desc[DESC_W-1 -: 8];
        w_nxt_state = ST_WSETTLE;
      end
      ST_WSETTLE: w_nxt_state = ST_WAIT;
      ST_WAIT: begin
        if (!dma_act) begin
          if (w_have) begin
            w_nxt_state = ST_LOAD;
            w_nxt_cnt   = '0;
            w_pop       = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_desc <= w_head;
  end

  // Sticky flags: a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dmaport_wr <= '0;
      r_dma_zdata  <= '0;
      r_chain_done <= 1'b0;
      r_z_conflict <= 1'b0;
      r_q_ovf      <= 1'b0;
    end else begin
      r_dmaport_wr <= w_strb;
      if (w_strb != '0) r_dma_zdata <= w_data;
      r_chain_done <= w_done;
      r_z_conflict <= w_conf_evt || (r_z_conflict && !err_clr);
      r_q_ovf      <= w_ovf_evt  || (r_q_ovf && !err_clr);
    end
  end

  assign dmaport_wr = r_dmaport_wr;
  assign dma_zdata  = r_dma_zdata;
  assign chain_done = r_chain_done;
  assign z_conflict = r_z_conflict;
  assign q_ovf      = r_q_ovf;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dma_seq.sv
// Directed, table-driven bench for the DMA descriptor sequencer.
module tb_dma_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] zdata;
  logic [8:0] zport_wr;
  logic       stg_wr;
  logic [3:0] stg_idx;
  logic       q_push, q_flush, err_clr, dma_act;
  logic [8:0] dmaport_wr;
  logic [7:0] dma_zdata;
  logic [2:0] q_level;
  logic       q_full, busy, chain_done, z_conflict, q_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [8:0] strb;
    logic [7:0] dat;
  } vec_t;

  vec_t       exp_v [9];
  logic [7:0] stg_b [9];

  always #5 clk = ~clk;

  dma_seq #(.DEPTH(4), .PW(9)) dut (
    .clk(clk), .rst_n(rst_n), .zdata(zdata), .zport_wr(zport_wr),
    .stg_wr(stg_wr), .stg_idx(stg_idx), .q_push(q_push), .q_flush(q_flush),
    .err_clr(err_clr), .dma_act(dma_act), .dmaport_wr(dmaport_wr),
    .dma_zdata(dma_zdata), .q_level(q_level), .q_full(q_full), .busy(busy),
    .chain_done(chain_done), .z_conflict(z_conflict), .q_ovf(q_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic push_one();
    q_push = 1'b1;
    step();
    q_push = 1'b0;
  endtask

  initial begin
    int launches, dones, cd;
    logic [8:0] acc;

    stg_b = '{8'h10, 8'h11, 8'h02, 8'h20, 8'h21, 8'h03, 8'h0F, 8'h00, 8'h81};
    exp_v[0] = '{9'h001, 8'h10};
    exp_v[1] = '{9'h002, 8'h11};
    exp_v[2] = '{9'h004, 8'h02};
    exp_v[3] = '{9'h008, 8'h20};
    exp_v[4] = '{9'h010, 8'h21};
    exp_v[5] = '{9'h020, 8'h03};
    exp_v[6] = '{9'h040, 8'h0F};
    exp_v[7] = '{9'h100, 8'h00};
    exp_v[8] = '{9'h080, 8'h81};

    rst_n = 1'b0; zdata = '0; zport_wr = '0; stg_wr = 1'b0; stg_idx = '0;
    q_push = 1'b0; q_flush = 1'b0; err_clr = 1'b0; dma_act = 1'b0;
    step(); step();
    chk("rst_dmaport", dmaport_wr, 0);
    chk("rst_zdata",   dma_zdata, 0);
    chk("rst_level",   q_level, 0);
    chk("rst_flags",   {q_full, busy, chain_done, z_conflict, q_ovf}, 0);
    rst_n = 1'b1;
    step();

    // Single descriptor; the push cycle also rewrites byte 0, which must not leak in
    for (int i = 0; i < 9; i++) begin
      stg_wr = 1'b1; stg_idx = 4'(i); zdata = stg_b[i];
      step();
    end
    stg_idx = 4'd0; zdata = 8'h99; q_push = 1'b1;
    step();
    stg_wr = 1'b0; q_push = 1'b0;
    chk("single_lvl1", q_level, 1);
    chk("single_idle", busy, 0);
    step();
    chk("single_busy", busy, 1);
    chk("single_pop",  q_level, 0);
    chk("single_gap",  dmaport_wr, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("single_strb%0d", i), dmaport_wr, exp_v[i].strb);
      chk($sformatf("single_dat%0d", i),  dma_zdata,  exp_v[i].dat);
    end
    dma_act = 1'b1;
    acc = '0;
    for (int i = 0; i < 50; i++) begin
      step();
      acc |= dmaport_wr;
    end
    chk("single_quiet", acc, 0);
    chk("single_hold",  dma_zdata, 8'h81);
    chk("single_wait",  busy, 1);
    dma_act = 1'b0;
    step();
    chk("single_done", chain_done, 1);
    chk("single_free", busy, 0);
    step();
    chk("single_pulse", chain_done, 0);

    // Restore byte 0 for the following tests
    stg_wr = 1'b1; stg_idx = 4'd0; zdata = 8'h10;
    step();
    stg_wr = 1'b0;

    // Chain of three with a modelled DMA busy for 20 cycles per launch
    dma_act = 1'b1;
    repeat (3) push_one();
    chk("chain_lvl3", q_level, 3);
    dma_act = 1'b0;
    launches = 0; dones = 0; cd = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (chain_done) dones++;
      if (dmaport_wr == 9'h080) begin
        launches++;
        chk($sformatf("chain_lvl_at_launch%0d", launches), q_level, 32'(3 - launches));
        cd = 20;
        dma_act = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) dma_act = 1'b0;
      end
      if (launches == 3 && !busy) break;
    end
    dma_act = 1'b0;
    chk("chain_launches", launches, 3);
    chk("chain_dones", dones, 1);
    chk("chain_idle", busy, 0);
    step();

    // Arbitration: direct write wins in IDLE, replay starts right after
    dma_act = 1'b1;
    push_one();
    step();
    dma_act = 1'b0; zport_wr = 9'h040; zdata = 8'h5A;
    step();
    chk("arb_direct", dmaport_wr, 9'h040);
    chk("arb_ddata",  dma_zdata, 8'h5A);
    chk("arb_defer",  busy, 0);
    zport_wr = '0;
    step();
    chk("arb_start", busy, 1);
    chk("arb_gap",   dmaport_wr, 0);
    step();
    chk("arb_first", dmaport_wr, 9'h001);
    zport_wr = 9'h001; zdata = 8'hEE; err_clr = 1'b1;
    step();
    chk("arb_drop",     dmaport_wr, 9'h002);
    chk("arb_dropdat",  dma_zdata, 8'h11);
    chk("arb_conf_win", z_conflict, 1);
    zport_wr = '0; err_clr = 1'b0;
    step();
    chk("arb_sticky", z_conflict, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("arb_clr", z_conflict, 0);
    wait_idle(40);
    step();

    // Direct launch makes the DMA busy; queue fills and overflows
    zport_wr = 9'h080; zdata = 8'h81;
    step();
    chk("full_direct", dmaport_wr, 9'h080);
    zport_wr = '0; dma_act = 1'b1;
    step();
    repeat (5) push_one();
    chk("full_level", q_level, 4);
    chk("full_flag",  q_full, 1);
    chk("full_ovf",   q_ovf, 1);
    acc = '0;
    repeat (3) begin step(); acc |= dmaport_wr; end
    chk("full_gate", {acc, busy}, 0);
    q_flush = 1'b1; q_push = 1'b1;
    step();
    q_flush = 1'b0; q_push = 1'b0;
    chk("flush_level", q_level, 0);
    chk("flush_full",  q_full, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", q_ovf, 0);

    // Gate on dma_act, then reset in the middle of LOAD
    push_one();
    push_one();
    chk("gate_level", q_level, 2);
    acc = '0;
    repeat (5) begin step(); acc |= dmaport_wr; end
    chk("gate_quiet", {acc, busy}, 0);
    dma_act = 1'b0;
    step();
    chk("gate_start", busy, 1);
    chk("gate_pop",   q_level, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("gate_strb%0d", i), dmaport_wr, exp_v[i].strb);
    end
    rst_n = 1'b0;
    step();
    chk("mrst_dmaport", dmaport_wr, 0);
    chk("mrst_level",   q_level, 0);
    chk("mrst_busy",    busy, 0);
    chk("mrst_zdata",   dma_zdata, 0);
    rst_n = 1'b1;
    acc = '0;
    repeat (20) begin step(); acc |= dmaport_wr; end
    chk("mrst_quiet", {acc, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
